int_request_ctrl: RTL and testbench
===================================

# int_request_ctrl

Interrupt request controller that drives the interrupt inputs of the CP0 register block. It synchronises raw external interrupt lines, latches them as pending, and arbitrates them against the CP0 interrupt mask and global enable. It presents one request with a 2-bit cause code to the pipeline and tracks in-service levels for nested interrupts. Entry is retired on pipeline acknowledge and exit on `eret`, so it is the initiator end of the interrupt interface whose responder is CP0.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth per interrupt line; legal range 2–4.
- `in_clk`  in  1  system clock; all state updates on the rising edge.
- `in_RST`  in  1  reset, asynchronous, active-low.
- `in_irq`  in  4  raw asynchronous interrupt lines. A rising edge is one request. Bit 0 has the highest priority, bit 3 the lowest.
- `in_INM`  in  4  CP0 interrupt mask; 1 = source enabled.
- `in_IE`  in  1  CP0 global interrupt enable.
- `in_ack`  in  1  single-cycle pulse: the pipeline has taken the current request and saved the EPC.
- `in_eret`  in  1  single-cycle pulse: an `eret` is retiring.
- `in_clr`  in  4  software clear of the pending and lost bits, one per source.
- `out_req`  out  1  interrupt request to the pipeline.
- `out_code`  out  2  index of the requested source; valid while `out_req` = 1.
- `out_pending`  out  4  latched pending requests.
- `out_inserv`  out  4  in-service levels (nesting stack as a bitmap).
- `out_lost`  out  4  sticky flag: an edge arrived while that source was already pending.

## Operation
- **Edge capture**
  - Each `in_irq[i]` passes through `SYNC_STAGES` flops, then a previous-value flop. Edge = synced & ~previous.
  - An edge sets `pending[i]`.
  - An edge while `pending[i]` is already 1 also sets `lost[i]`.
- **Clear rules**
  - `in_clr[i]` clears `pending[i]` and `lost[i]`.
  - If an edge and `in_clr[i]` occur in the same cycle, the set wins.
- **Eligibility:** source `i` is eligible when all of the following hold:
  - `pending[i]` = 1;
  - `in_INM[i]` = 1;
  - `in_IE` = 1;
  - `i` is strictly lower in index than the lowest set bit of `inserv`, or `inserv` is 0.
- **Winner:** the lowest-index eligible source.
- **State machine, two states**
  - IDLE: `out_req` = 0. When any source is eligible, register `out_code` = winner and go to REQ.
  - REQ: `out_req` = 1. `out_code` is frozen; there is no re-arbitration even if a higher-priority source becomes eligible.
    - `in_ack`: clear `pending[code]`, set `inserv[code]`, go to IDLE.
    - Withdraw, no `in_ack`: if `in_IE` = 0 or `in_INM[code]` = 0 in that cycle, go to IDLE with the pending bit kept.
    - `in_ack` wins over withdrawal in the same cycle.
- **Ignored inputs**
  - `in_ack` in IDLE.
  - `in_eret` with `inserv` = 0.
- **`in_eret`:** clears the lowest set bit of `inserv`, i.e. the highest-priority active level.
- **Same-cycle ordering** of `in_eret`, `in_ack`, a new edge and `in_clr`:
  - `in_eret` clears from the old `inserv`, then `in_ack` sets the new bit.
  - An edge on `code` in the same cycle as `in_ack` leaves `pending[code]` = 1 and does not set `lost`.
  - `in_clr` of `pending[code]` while in REQ causes a withdrawal the next cycle.

## Timing
- **Reset:** all of the following reset to 0 and the state resets to IDLE:
  - `out_req`, `out_code`, `out_pending`, `out_inserv`, `out_lost`;
  - all synchroniser and previous-value flops.
- **Edge blanking after reset:** edge detection is disabled for `SYNC_STAGES`+1 cycles after `in_RST` deasserts. A line held high through reset release therefore never produces a request.
- **Capture latency:** a rise on `in_irq` first sampled at edge n appears on `out_pending` after edge n+`SYNC_STAGES`.
- **Request latency:** `out_req` rises one edge after the source becomes eligible. All outputs are registered.
- **After ack:** `out_req` is 0 in the cycle after `in_ack`. The earliest next request is one cycle later, so the minimum request spacing is 2 cycles.
- **Withdrawal:** `out_req` falls at the edge where the condition is sampled.
- **Reset mid-operation:** asserting `in_RST` while in REQ clears `out_req` immediately (asynchronous). The pending request is lost.

## Test plan
- **Single request, ack:** 3 cycles after reset release, pulse `in_irq`=4'b0100 high for 3 cycles, with `in_INM`=4'hF and `in_IE`=1 → `out_pending`=4'b0100 at edge +2. `out_req`=1 and `out_code`=2 one edge later. Then `in_ack` → `out_pending`=0 and `out_inserv`=4'b0100.
- **Priority, freeze and nesting:**
  - Raise sources 3 and 1 in the same cycle → `out_code`=1.
  - Raise source 0 while in REQ → `out_code` stays 1.
  - `in_ack` → next `out_code`=0 (nesting over level 1).
  - `in_ack` → `out_inserv`=4'b0011.
  - Source 3 remains pending and gets no request until two `in_eret` pulses are applied (`out_inserv`=0), after which `out_code`=3.
- **Mask and withdrawal:** in REQ with `out_code`=2, drop `in_INM[2]` for one cycle → `out_req`=0 the next cycle and `out_pending[2]`=1. Restore the mask → `out_req` returns with `out_code`=2.
- **Lost and clear:** two `in_irq[1]` edges with no ack → `out_lost`=4'b0010. `in_clr`=4'b0010 in the same cycle as a third edge → pending is set and `out_lost` is cleared.
- **Simultaneous and reset edge cases:**
  - `in_ack` and `in_eret` in the same cycle with `inserv`=4'b0100 and `code`=1 → `out_inserv`=4'b0010.
  - `in_irq` held high through reset release → no request.
  - Assert `in_RST` while in REQ → `out_req`=0 with no clock edge.

Source files
------------

// File: rtl/int_request_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : int_request_ctrl_if
// Description : Interrupt request interface between the request controller
//               (master, initiator) and the CP0 / pipeline side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface int_request_ctrl_if;
  logic [3:0] in_irq;
  logic [3:0] in_INM;
  logic       in_IE;
  logic       in_ack;
  logic       in_eret;
  logic [3:0] in_clr;
  logic       out_req;
  logic [1:0] out_code;
  logic [3:0] out_pending;
  logic [3:0] out_inserv;
  logic [3:0] out_lost;

  modport master (
    input  in_irq, in_INM, in_IE, in_ack, in_eret, in_clr,
    output out_req, out_code, out_pending, out_inserv, out_lost
  );

  modport slave (
    output in_irq, in_INM, in_IE, in_ack, in_eret, in_clr,
    input  out_req, out_code, out_pending, out_inserv, out_lost
  );
endinterface
`default_nettype wire

// File: rtl/int_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_request_ctrl
// Description : Synchronises four raw interrupt lines, latches rising edges as
//               pending, arbitrates against mask/enable/in-service level and
//               presents one request with a 2-bit cause code.
// Revision    : 1.0 - initial release
// ============================================================================
module int_request_ctrl #(
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                   in_clk,
  input  logic                   in_RST,
  int_request_ctrl_if.master     bus
);

  localparam int         BLANK_CYCLES = SYNC_STAGES + 1;
  localparam logic [2:0] BLANK_LAST   = 3'(BLANK_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] prev_q;
  logic [2:0] blank_q;
  logic       blank_done;
  logic [3:0] edge_w;

  logic [3:0] pending_q, pending_d;
  logic [3:0] lost_q,    lost_d;
  logic [3:0] inserv_q,  inserv_d;

  state_t     state_q;
  logic       req_q;
  logic [1:0] code_q;

  logic [3:0] ack_clr;
  logic [3:0] lowbit;
  logic [3:0] elig;
  logic [1:0] win;
  logic       withdraw;

  // Synchroniser chain followed by the previous-value flop for edge detection
  always_ff @(posedge in_clk or negedge in_RST) begin
    if (!in_RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus.in_irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Blanking counter: a line already high at reset release must not look like an edge
  always_ff @(posedge in_clk or negedge in_RST) begin
    if (!in_RST)          blank_q <= '0;
    else if (!blank_done) blank_q <= blank_q + 3'd1;
  end

  assign blank_done = (blank_q == BLANK_LAST);
  assign edge_w     = sync_q[SYNC_STAGES-1] & ~prev_q & {4{blank_done}};

  // Only the lowest in-service level matters: anything strictly below it may nest
  assign lowbit   = inserv_q & (~inserv_q + 4'd1);
  assign elig     = pending_q & bus.in_INM & {4{bus.in_IE}} & (lowbit - 4'd1);
  assign ack_clr  = (state_q == ST_REQ && bus.in_ack) ? (4'b0001 << code_q) : 4'b0000;
  assign withdraw = !bus.in_IE || !bus.in_INM[code_q] || !pending_q[code_q];

  // Fixed priority: bit 0 wins
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) win = 2'(i);
    end
  end

  // Pending/lost/in-service next state; an incoming edge overrides clears
  always_comb begin
    pending_d = edge_w | (pending_q & ~bus.in_clr & ~ack_clr);
    lost_d    = ~bus.in_clr & (lost_q | (edge_w & pending_q & ~ack_clr));
    inserv_d  = bus.in_eret ? (inserv_q & (inserv_q - 4'd1)) : inserv_q;
    inserv_d  = inserv_d | ack_clr;
  end

  // Pending, lost and in-service registers
  always_ff @(posedge in_clk or negedge in_RST) begin
    if (!in_RST) begin
      pending_q <= '0;
      lost_q    <= '0;
      inserv_q  <= '0;
    end else begin
      pending_q <= pending_d;
      lost_q    <= lost_d;
      inserv_q  <= inserv_d;
    end
  end

  // Request FSM: code is frozen while requesting, ack beats withdrawal
  always_ff @(posedge in_clk or negedge in_RST) begin
    if (!in_RST) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|elig) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            code_q  <= win;
          end
        end
        ST_REQ: begin
          if (bus.in_ack || withdraw) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_req     = req_q;
  assign bus.out_code    = code_q;
  assign bus.out_pending = pending_q;
  assign bus.out_inserv  = inserv_q;
  assign bus.out_lost    = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_int_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_request_ctrl
// Description : Directed scenarios plus randomized traffic for int_request_ctrl,
//               checked every cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_request_ctrl;
  localparam int SYNC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  int_request_ctrl_if bus ();

  int_request_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .in_clk (clk),
    .in_RST (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [3:0] m_pend, m_lost, m_inserv;
  bit       m_req;
  bit [1:0] m_code;
  int       m_e;
  bit [3:0] m_samp [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_pend = 0; m_lost = 0; m_inserv = 0; m_req = 0; m_code = 0; m_e = 0;
    m_samp.delete();
  endtask

  // One clock edge of the model, using the inputs presented before the edge
  task automatic model_edge();
    bit [3:0] edg, np, nl, ni;
    bit       ackd, taken;
    int       lo;
    m_e++;
    m_samp.push_back(bus.in_irq);
    edg = 0;
    if (m_e >= SYNC + 2) edg = m_samp[m_e-SYNC-1] & ~m_samp[m_e-SYNC-2];
    ackd = m_req && bus.in_ack;
    for (int i = 0; i < 4; i++) begin
      taken = ackd && (m_code == 2'(i));
      np[i] = edg[i] ? 1'b1 : ((bus.in_clr[i] || taken) ? 1'b0 : m_pend[i]);
      nl[i] = bus.in_clr[i] ? 1'b0 : (m_lost[i] || (edg[i] && m_pend[i] && !taken));
    end
    ni = m_inserv;
    if (bus.in_eret) begin
      for (int i = 0; i < 4; i++) if (ni[i]) begin ni[i] = 1'b0; break; end
    end
    if (ackd) ni[m_code] = 1'b1;
    if (!m_req) begin
      lo = 4;
      for (int i = 3; i >= 0; i--) if (m_inserv[i]) lo = i;
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i] && bus.in_INM[i] && bus.in_IE && i < lo) begin
          m_req = 1; m_code = 2'(i); break;
        end
      end
    end else if (bus.in_ack) begin
      m_req = 0;
    end else if (!bus.in_IE || !bus.in_INM[m_code] || !m_pend[m_code]) begin
      m_req = 0;
    end
    m_pend = np; m_lost = nl; m_inserv = ni;
  endtask

  task automatic compare_all();
    check("req", 32'(bus.out_req), 32'(m_req));
    if (m_req) check("code", 32'(bus.out_code), 32'(m_code));
    check("pending", 32'(bus.out_pending), 32'(m_pend));
    check("inserv", 32'(bus.out_inserv), 32'(m_inserv));
    check("lost", 32'(bus.out_lost), 32'(m_lost));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_req(input string tag, input int budget);
    for (int k = 0; k < budget && !bus.out_req; k++) step();
    check(tag, 32'(bus.out_req), 32'd1);
  endtask

  task automatic pulse_ack();
    bus.in_ack = 1'b1; step(); bus.in_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    bus.in_eret = 1'b1; step(); bus.in_eret = 1'b0;
  endtask

  // Assert (if not already) and release reset; release lands just after a falling edge
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.in_ack = 0; bus.in_eret = 0; bus.in_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.out_req), 32'd0);
    check("rst_code", 32'(bus.out_code), 32'd0);
    check("rst_pending", 32'(bus.out_pending), 32'd0);
    check("rst_inserv", 32'(bus.out_inserv), 32'd0);
    check("rst_lost", 32'(bus.out_lost), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] t;
    bus.in_irq = 0; bus.in_INM = 4'hF; bus.in_IE = 1; bus.in_ack = 0;
    bus.in_eret = 0; bus.in_clr = 0;
    apply_reset();

    // Single request and acknowledge
    steps(3);
    bus.in_irq = 4'b0100;
    steps(3);
    check("single_pending", 32'(bus.out_pending), 32'b0100);
    bus.in_irq = 4'b0000;
    step();
    check("single_req", 32'(bus.out_req), 32'd1);
    check("single_code", 32'(bus.out_code), 32'd2);
    pulse_ack();
    check("single_ack_pending", 32'(bus.out_pending), 32'd0);
    check("single_ack_inserv", 32'(bus.out_inserv), 32'b0100);
    pulse_eret();

    // Priority, freeze and nesting
    bus.in_irq = 4'b1010;
    wait_req("prio_wait1", 10);
    check("prio_code1", 32'(bus.out_code), 32'd1);
    bus.in_irq = 4'b1011;
    steps(4);
    check("freeze_code", 32'(bus.out_code), 32'd1);
    pulse_ack();
    wait_req("nest_wait", 10);
    check("nest_code0", 32'(bus.out_code), 32'd0);
    pulse_ack();
    check("nest_inserv", 32'(bus.out_inserv), 32'b0011);
    steps(5);
    check("blocked_req", 32'(bus.out_req), 32'd0);
    pulse_eret();
    pulse_eret();
    wait_req("eret_wait", 10);
    check("after_eret_code", 32'(bus.out_code), 32'd3);
    pulse_ack();

    // Mask withdrawal and return
    bus.in_irq = 4'b1111;
    wait_req("mask_wait1", 10);
    check("mask_code", 32'(bus.out_code), 32'd2);
    bus.in_INM = 4'b1011;
    step();
    bus.in_INM = 4'hF;
    check("withdraw_req", 32'(bus.out_req), 32'd0);
    check("withdraw_pend2", 32'(bus.out_pending[2]), 32'd1);
    wait_req("mask_wait2", 10);
    check("mask_code_again", 32'(bus.out_code), 32'd2);
    pulse_ack();

    // Lost flag and same-cycle clear against a new edge
    bus.in_irq = 4'b1101; steps(3);
    bus.in_irq = 4'b1111; steps(3);
    bus.in_irq = 4'b1101; steps(3);
    bus.in_irq = 4'b1111; steps(4);
    check("lost_set", 32'(bus.out_lost), 32'b0010);
    bus.in_irq = 4'b1101; steps(3);
    bus.in_irq = 4'b1111; steps(2);
    bus.in_clr = 4'b0010; step(); bus.in_clr = 4'b0000;
    check("clr_edge_pend1", 32'(bus.out_pending[1]), 32'd1);
    check("clr_edge_lost", 32'(bus.out_lost), 32'd0);

    // Simultaneous ack and eret
    bus.in_irq = 4'b0000;
    apply_reset();
    steps(4);
    bus.in_irq = 4'b0100;
    wait_req("sim_wait1", 10);
    pulse_ack();
    bus.in_irq = 4'b0110;
    wait_req("sim_wait2", 10);
    check("sim_code", 32'(bus.out_code), 32'd1);
    bus.in_ack = 1; bus.in_eret = 1; step(); bus.in_ack = 0; bus.in_eret = 0;
    check("sim_inserv", 32'(bus.out_inserv), 32'b0010);

    // Lines held high through reset release
    bus.in_irq = 4'hF;
    apply_reset();
    steps(12);
    check("held_req", 32'(bus.out_req), 32'd0);
    check("held_pending", 32'(bus.out_pending), 32'd0);

    // Asynchronous reset while requesting
    bus.in_irq = 4'h0; steps(3);
    bus.in_irq = 4'h1;
    wait_req("async_wait", 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 32'(bus.out_req), 32'd0);
    check("async_pending", 32'(bus.out_pending), 32'd0);
    bus.in_irq = 4'h0;
    apply_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      t = 0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) t[b] = 1'b1;
      bus.in_irq  = bus.in_irq ^ t;
      bus.in_INM  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
      bus.in_IE   = ($urandom_range(0, 15) != 0);
      bus.in_ack  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus.in_eret = ($urandom_range(0, 7) == 0);
      t = 0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 31) == 0) t[b] = 1'b1;
      bus.in_clr  = t;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
